// File: rtl/mc_fetch_regs.sv
// Multicycle MIPS fetch/decode register stage: PC, IR, MDR, ALUOut, debug counters and sticky error flags.
// Latency: all registers update one clkvar edge after their enables; mem_addr and IR-derived fields are combinational.
// Backpressure: none; the stage is fully slaved to the controller's per-state enables and never stalls.
module mc_fetch_regs #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clkvar,
   input  logic             rst,
   input  logic             PCWrite,
   input  logic             PCWriteCond,
   input  logic             PCWriteCondne,
   input  logic [1:0]       PCSource,
   input  logic             IRWrite,
   input  logic             IorD,
   input  logic [31:0]      alu_result,
   input  logic             alu_zero,
   input  logic [31:0]      mem_rdata,
   output logic [31:0]      pc,
   output logic [31:0]      ir,
   output logic [31:0]      mdr,
   output logic [31:0]      alu_out,
   output logic [31:0]      mem_addr,
   output logic [5:0]       op,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [5:0]       funct,
   output logic [31:0]      imm_sext,
   output logic [31:0]      imm_sh2,
   output logic [31:0]      jump_target,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] br_taken_cnt,
   output logic             pcsrc_err,
   output logic             align_err
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      ir_q;
   logic [31:0]      mdr_q;
   logic [31:0]      alu_out_q;
   logic [CNT_W-1:0] cycle_cnt_q;
   logic [CNT_W-1:0] instr_cnt_q;
   logic [CNT_W-1:0] br_taken_cnt_q;
   logic             pcsrc_err_q;
   logic             align_err_q;

   logic             pc_en;
   logic             pcsrc_bad;
   logic             br_taken;
   logic [31:0]      jump_target_w;
   logic [31:0]      imm_sext_w;

   assign pc_en         = PCWrite | (PCWriteCond & alu_zero) | (PCWriteCondne & ~alu_zero);
   assign pcsrc_bad     = pc_en & (PCSource == 2'b11);
   // A taken conditional branch is a PC write that came only from the beq/bne enables.
   assign br_taken      = ~PCWrite & pc_en & (PCWriteCond | PCWriteCondne);
   // Jump target uses the already-incremented PC, matching the MIPS delay-free multicycle model.
   assign jump_target_w = {pc_q[31:28], ir_q[25:0], 2'b00};
   assign imm_sext_w    = {{16{ir_q[15]}}, ir_q[15:0]};

   // Next-PC select; the illegal encoding keeps the current PC.
   always_comb begin
      pc_d = pc_q;
      case (PCSource)
         2'b00:   pc_d = alu_result;
         2'b01:   pc_d = alu_out_q;
         2'b10:   pc_d = jump_target_w;
         default: pc_d = pc_q;
      endcase
   end

   // Architectural datapath registers: PC, IR, MDR and ALUOut.
   always_ff @(posedge clkvar or posedge rst) begin
      if (rst) begin
         pc_q      <= PC_RESET;
         ir_q      <= 32'h0;
         mdr_q     <= 32'h0;
         alu_out_q <= 32'h0;
      end else begin
         alu_out_q <= alu_result;
         mdr_q     <= mem_rdata;
         if (IRWrite) begin
            ir_q <= mem_rdata;
         end
         if (pc_en && !pcsrc_bad) begin
            pc_q <= pc_d;
         end
      end
   end

   // Debug counters and sticky error flags; the flags clear only on reset.
   always_ff @(posedge clkvar or posedge rst) begin
      if (rst) begin
         cycle_cnt_q    <= '0;
         instr_cnt_q    <= '0;
         br_taken_cnt_q <= '0;
         pcsrc_err_q    <= 1'b0;
         align_err_q    <= 1'b0;
      end else begin
         cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
         if (IRWrite) begin
            instr_cnt_q <= instr_cnt_q + CNT_ONE;
         end
         if (br_taken) begin
            br_taken_cnt_q <= br_taken_cnt_q + CNT_ONE;
         end
         if (pcsrc_bad) begin
            pcsrc_err_q <= 1'b1;
         end
         // Misaligned targets are still written in full so software can see where it went.
         if (pc_en && !pcsrc_bad && (pc_d[1:0] != 2'b00)) begin
            align_err_q <= 1'b1;
         end
      end
   end

   assign pc           = pc_q;
   assign ir           = ir_q;
   assign mdr          = mdr_q;
   assign alu_out      = alu_out_q;
   assign mem_addr     = IorD ? alu_out_q : pc_q;
   assign op           = ir_q[31:26];
   assign rs           = ir_q[25:21];
   assign rt           = ir_q[20:16];
   assign rd           = ir_q[15:11];
   assign funct        = ir_q[5:0];
   assign imm_sext     = imm_sext_w;
   assign imm_sh2      = {imm_sext_w[29:0], 2'b00};
   assign jump_target  = jump_target_w;
   assign cycle_cnt    = cycle_cnt_q;
   assign instr_cnt    = instr_cnt_q;
   assign br_taken_cnt = br_taken_cnt_q;
   assign pcsrc_err    = pcsrc_err_q;
   assign align_err    = align_err_q;

endmodule

// File: doc/mc_fetch_regs.md
Name: mc_fetch_regs

Overview:
- Multicycle MIPS datapath register stage directly downstream of the main control FSM.
- Consumes PCWrite/PCWriteCond/PCWriteCondne/PCSource/IRWrite/IorD from the controller, plus ALU result/zero and memory read data.
- Owns PC, IR, MDR and ALUOut; drives the memory address and feeds op[5:0] back to the controller.
- Also holds instruction/cycle/branch counters and sticky error flags for the debug display.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the cycle, instruction and branch counters.

Ports:
- clkvar  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCWrite  in  1  unconditional PC write enable.
- PCWriteCond  in  1  PC write if alu_zero=1 (beq).
- PCWriteCondne  in  1  PC write if alu_zero=0 (bne).
- PCSource  in  2  next-PC select: 00 alu_result, 01 alu_out, 10 jump target, 11 illegal.
- IRWrite  in  1  load IR from mem_rdata.
- IorD  in  1  memory address select: 0 pc, 1 alu_out.
- alu_result  in  32  combinational ALU output.
- alu_zero  in  1  ALU zero flag.
- mem_rdata  in  32  memory read data.
- pc  out  32  program counter.
- ir  out  32  instruction register.
- mdr  out  32  memory data register.
- alu_out  out  32  registered ALU result.
- mem_addr  out  32  IorD ? alu_out : pc (combinational).
- op  out  6  ir[31:26].
- rs, rt, rd  out  5 each  ir[25:21], ir[20:16], ir[15:11].
- funct  out  6  ir[5:0].
- imm_sext  out  32  sign-extended ir[15:0].
- imm_sh2  out  32  imm_sext shifted left 2.
- jump_target  out  32  {pc[31:28], ir[25:0], 2'b00}.
- cycle_cnt  out  CNT_W  clock cycles since reset.
- instr_cnt  out  CNT_W  IR loads since reset.
- br_taken_cnt  out  CNT_W  taken conditional branches since reset.
- pcsrc_err  out  1  sticky: PC write attempted with PCSource=11.
- align_err  out  1  sticky: PC written with nonzero bits [1:0].

Behaviour:
- Reset (async, immediate): pc=PC_RESET; ir, mdr, alu_out, all counters = 0; pcsrc_err = align_err = 0. Outputs derived from ir/pc follow combinationally, so op=0 after reset.
- Every clkvar edge (rst low):
  - alu_out <= alu_result unconditionally.
  - mdr <= mem_rdata unconditionally.
  - cycle_cnt increments, wrapping at 2^CNT_W.
- IR: if IRWrite=1, ir <= mem_rdata and instr_cnt increments (wrap); otherwise ir holds.
  - op is valid in the cycle after the IRWrite cycle, when the controller decodes it.
- PC enable: pc_en = PCWrite | (PCWriteCond & alu_zero) | (PCWriteCondne & ~alu_zero). Simultaneous enables OR together.
- Next PC:
  - PCSource 00 -> alu_result (fetch PC+4).
  - PCSource 01 -> alu_out (branch target computed in decode).
  - PCSource 10 -> jump_target, built from the current (already incremented) pc.
  - PCSource 11 with pc_en=1 -> pc holds and pcsrc_err sets.
- Branch counting: br_taken_cnt increments when PCWrite=0, pc_en=1 and (PCWriteCond or PCWriteCondne) is set, i.e. a taken beq/bne.
- Alignment: when pc_en=1 and the selected next-PC has bits [1:0] != 0, pc is still written with the full value and align_err sets.
- Sticky flags clear only on rst.
- Latency:
  - mem_addr, op, field and immediate outputs: combinational, zero latency.
  - All registers: one cycle.
- Reset mid-instruction: state returns to reset values immediately; no partial PC/IR update survives.
- No internal FSM sequencing: the stage is fully slaved to the controller's per-state signals. The counters and sticky flags are its only autonomous state.

Test Plan:
- Reset: assert rst with PC_RESET=0 mid-cycle -> pc=0, ir=0, op=0, all counters 0, both error flags 0 without waiting for a clock edge.
- Fetch: IRWrite=1, PCWrite=1, PCSource=00, mem_rdata=32'h2008_0005, alu_result=4 -> next edge pc=4, ir=32'h2008_0005, op=6'b001000, rt=8, imm_sext=5, instr_cnt=1.
- beq: alu_out=32'h40, PCWriteCond=1, PCSource=01.
  - alu_zero=1 -> pc=32'h40, br_taken_cnt=1.
  - Repeat with alu_zero=0 -> pc unchanged, br_taken_cnt unchanged.
- bne / jump:
  - PCWriteCondne=1, alu_zero=0, PCSource=01 -> pc=alu_out.
  - Then pc=32'h1000_0004, ir=32'h0800_0010, PCWrite=1, PCSource=10 -> pc=32'h1000_0040.
- lw address / MDR: IorD=1 with alu_out=32'h0000_0008 -> mem_addr=8 combinationally; mem_rdata=32'hDEAD_BEEF -> mdr=32'hDEAD_BEEF after one edge.
- Errors:
  - PCWrite=1, PCSource=11 -> pc holds, pcsrc_err=1, stays set across later cycles.
  - PCWrite=1, PCSource=00, alu_result=32'h6 -> pc=6, align_err=1.
  - rst clears both flags.
